// File: rtl/clk_en_scheduler.sv
// Shared clock-enable scheduler: one base-tick prescaler feeding
// NUM_CH independent programmable divide-by-N enable strobes.
module clk_en_scheduler #(
   parameter  int PRESCALE = 16,
   parameter  int NUM_CH   = 4,
   parameter  int CNT_W    = 16,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PRE_W    = $clog2(PRESCALE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic              cfg_en,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic              base_tick,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] ch_active,
   output logic [NUM_CH-1:0] ch_pend
);

   typedef enum logic {DISABLED, RUN} ch_state_e;

   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic              bt;
   logic              base_tick_q;
   ch_state_e         state_q [NUM_CH];
   ch_state_e         state_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [CNT_W-1:0]  div_q   [NUM_CH];
   logic [CNT_W-1:0]  div_d   [NUM_CH];
   logic [CNT_W-1:0]  pdiv_q  [NUM_CH];
   logic [CNT_W-1:0]  pdiv_d  [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] hit;
   logic              wr_on;

   assign bt    = (pre_cnt_q == PRE_W'(PRESCALE - 1));
   assign wr_on = cfg_en && (cfg_div != '0);

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      end
   end

   always_comb begin
      pre_cnt_d = bt ? '0 : pre_cnt_q + 1'b1;
      pend_d    = pend_q;
      tick_d    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         div_d[i]   = div_q[i];
         pdiv_d[i]  = pdiv_q[i];
         if (hit[i] && !wr_on) begin
            state_d[i] = DISABLED;
            cnt_d[i]   = '0;
            pend_d[i]  = 1'b0;
         end else begin
            unique case (state_q[i])
               DISABLED: begin
                  if (hit[i]) begin
                     state_d[i] = RUN;
                     div_d[i]   = cfg_div;
                     cnt_d[i]   = cfg_div - 1'b1;
                     pend_d[i]  = 1'b0;
                  end
               end
               RUN: begin
                  if (bt && cnt_q[i] == '0) begin
                     tick_d[i] = 1'b1;
                     // a write landing on the reload edge bypasses pend
                     if (hit[i]) begin
                        div_d[i]  = cfg_div;
                        cnt_d[i]  = cfg_div - 1'b1;
                        pend_d[i] = 1'b0;
                     end else if (pend_q[i]) begin
                        div_d[i]  = pdiv_q[i];
                        cnt_d[i]  = pdiv_q[i] - 1'b1;
                        pend_d[i] = 1'b0;
                     end else begin
                        cnt_d[i] = div_q[i] - 1'b1;
                     end
                  end else begin
                     if (bt) cnt_d[i] = cnt_q[i] - 1'b1;
                     if (hit[i]) begin
                        pdiv_d[i] = cfg_div;
                        pend_d[i] = 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt_q   <= '0;
         base_tick_q <= 1'b0;
         tick_q      <= '0;
         pend_q      <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= DISABLED;
            cnt_q[i]   <= '0;
            div_q[i]   <= '0;
            pdiv_q[i]  <= '0;
         end
      end else begin
         pre_cnt_q   <= pre_cnt_d;
         base_tick_q <= bt;
         tick_q      <= tick_d;
         pend_q      <= pend_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            div_q[i]   <= div_d[i];
            pdiv_q[i]  <= pdiv_d[i];
         end
      end
   end

   always_comb begin
      ch_active = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_active[i] = (state_q[i] == RUN);
      end
   end

   assign base_tick = base_tick_q;
   assign tick      = tick_q;
   assign ch_pend   = pend_q;

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Bench for clk_en_scheduler: directed plan plus random config writes,
// checked against an event-time model (absolute tick cycle per channel).
module tb_clk_en_scheduler;
   localparam int P  = 16;
   localparam int NC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic        cfg_en = 1'b0;
   logic [15:0] cfg_div = '0;
   logic        base_tick;
   logic [3:0]  tick, ch_active, ch_pend;

   int checks = 0;
   int errors = 0;
   int n = 0;

   bit         m_act  [NC];
   bit         m_pend [NC];
   int         m_div  [NC];
   int         m_pdiv [NC];
   int         m_next [NC];
   logic [3:0] m_tick;

   always #5 clk = ~clk;

   clk_en_scheduler #(.PRESCALE(P), .NUM_CH(NC), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_en(cfg_en), .cfg_div(cfg_div), .base_tick(base_tick),
      .tick(tick), .ch_active(ch_active), .ch_pend(ch_pend)
   );

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h",
                tag, n, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_act[i]  = 1'b0;
         m_pend[i] = 1'b0;
         m_div[i]  = 0;
         m_pdiv[i] = 0;
         m_next[i] = 0;
      end
      m_tick = '0;
      n = 0;
   endtask

   // one rising edge: ticks land on absolute cycles that are multiples of P
   task automatic model_edge();
      bit fire, hit, on;
      n++;
      m_tick = '0;
      on = cfg_en && (cfg_div != 0);
      for (int i = 0; i < NC; i++) begin
         fire = m_act[i] && (n == m_next[i]);
         hit  = cfg_we && (int'(cfg_ch) == i);
         if (hit && !on) begin
            m_act[i]  = 1'b0;
            m_pend[i] = 1'b0;
         end else if (hit && !m_act[i]) begin
            m_act[i]  = 1'b1;
            m_div[i]  = int'(cfg_div);
            m_pend[i] = 1'b0;
            m_next[i] = (n / P + int'(cfg_div)) * P;
         end else if (fire) begin
            m_tick[i] = 1'b1;
            if (hit) m_div[i] = int'(cfg_div);
            else if (m_pend[i]) m_div[i] = m_pdiv[i];
            m_pend[i] = 1'b0;
            m_next[i] = n + m_div[i] * P;
         end else if (hit) begin
            m_pdiv[i] = int'(cfg_div);
            m_pend[i] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      logic [3:0] ea, ep;
      logic       eb;
      eb = (n > 0) && (n % P == 0);
      for (int i = 0; i < NC; i++) begin
         ea[i] = m_act[i];
         ep[i] = m_pend[i];
      end
      chk("base_tick", {3'b0, base_tick}, {3'b0, eb});
      chk("tick", tick, m_tick);
      chk("ch_active", ch_active, ea);
      chk("ch_pend", ch_pend, ep);
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_base_tick"}, {3'b0, base_tick}, 4'h0);
      chk({tag, "_tick"}, tick, 4'h0);
      chk({tag, "_ch_active"}, ch_active, 4'h0);
      chk({tag, "_ch_pend"}, ch_pend, 4'h0);
   endtask

   task automatic step(bit we, int ch, bit en, int dv);
      cfg_we  = we;
      cfg_ch  = ch[1:0];
      cfg_en  = en;
      cfg_div = dv[15:0];
      @(posedge clk);
      model_edge();
      #1 check_all();
   endtask

   task automatic idle_to(int c);
      while (n < c) step(0, 0, 0, 0);
   endtask

   initial begin
      int r, dv;
      model_reset();
      #2 check_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      idle_to(4);   step(1, 0, 1, 3);
      idle_to(9);   step(1, 1, 1, 2);
      idle_to(19);  step(1, 2, 1, 4);
      idle_to(21);  step(1, 2, 1, 5);
      idle_to(23);  step(1, 3, 1, 1);
      idle_to(59);  step(1, 0, 1, 1);
      idle_to(63);  step(1, 1, 0, 2);
      idle_to(170); step(1, 3, 1, 0);
      idle_to(175); step(1, 1, 1, 65535);
      idle_to(200);

      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, 15);
            dv = (r == 0) ? 0 : (r == 15) ? 65535 : (r % 5) + 1;
            step(1, $urandom_range(0, NC - 1), ($urandom_range(0, 7) != 0), dv);
         end else begin
            step(0, 0, 0, 0);
         end
      end

      cfg_we = 1'b0;
      #2 rst = 1'b0;
      #1 check_zero("async_rst");
      repeat (3) begin
         @(posedge clk);
         #1 check_zero("in_rst");
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      idle_to(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
